rr_mux8to1: RTL
===============

RR_MUX8TO1 -- requirements
Module: rr_mux8to1

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the per-channel payload width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the transfer counter width.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port i_valid  input  8  per-channel data valid.
REQ-006 The block SHALL have port i_data  input  8*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W].
REQ-007 The block SHALL have port i_ready  output  8  per-channel accept, one-hot or zero.
REQ-008 The block SHALL have port en_mask  input  8  channel enable; a 0 bit excludes that channel from arbitration.
REQ-009 The block SHALL have port y_valid  output  1  output payload valid.
REQ-010 The block SHALL have port y_data  output  DATA_W  selected payload.
REQ-011 The block SHALL have port y_sel  output  3  index of the source channel of y_data.
REQ-012 The block SHALL have port y_ready  input  1  downstream accept.
REQ-013 The block SHALL have port xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-014 The block SHALL treat a channel k as requesting when i_valid[k] & en_mask[k] is 1.
REQ-015 The block SHALL set the output register "free" when y_valid==0, or when y_valid==1 and y_ready==1, in the same cycle.
REQ-016 When free and at least one channel requests, the block SHALL grant exactly one channel k, drive i_ready[k]=1 combinationally, and on the clock edge load y_data=i_data[k], y_sel=k, y_valid=1.
REQ-017 When free and no channel requests, the block SHALL drive i_ready=0 and clear y_valid on the edge.
REQ-018 When not free, the block SHALL hold i_ready=0 and keep y_valid, y_data and y_sel stable.
REQ-019 The block SHALL arbitrate round-robin: the search starts at (last_grant+1) mod 8 and takes the first requesting index in increasing order, wrapping 7->0.
REQ-020 The block SHALL update last_grant only on a cycle in which a grant occurs.
REQ-021 The block SHALL have a latency of 1 cycle from a granted input handshake to y_valid, and SHALL sustain 1 transfer/cycle when y_ready is held 1.
REQ-022 The block SHALL increment xfer_cnt on every cycle with y_valid & y_ready, and SHALL saturate it at 2^CNT_W-1 with no wrap.
REQ-023 A channel whose en_mask bit drops while it holds y_data SHALL still have that word delivered; the mask affects future grants only.
REQ-024 The block SHALL leave i_data of non-granted channels ignored, and i_valid of those channels SHALL not be dropped by the block.

Reset
REQ-025 On rst_n==0, asynchronously: y_valid=0, y_data=0, y_sel=0, xfer_cnt=0, and last_grant=7 so that channel 0 is searched first.
REQ-026 During reset, i_ready SHALL be 0.
REQ-027 A word held in the output register when reset asserts SHALL be discarded and not counted.
REQ-028 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 A shared package mux_pkg SHALL hold N_CH=8, SEL_W=3 and the default DATA_W and CNT_W constants.
REQ-030 The round-robin priority search SHALL be a sub-module rr_arb8 with inputs req[7:0] and last[2:0], and outputs gnt_vld and gnt_idx[2:0], purely combinational.
REQ-031 The output register, last_grant pointer and counter SHALL live in rr_mux8to1.

Verification
REQ-032 Reset, then i_valid=8'hFF, en_mask=8'hFF, y_ready=1, i_data[k]=8'h10+k -> y_sel sequence 0,1,...,7,0 on consecutive cycles, y_data=8'h10..8'h17, xfer_cnt=8 after 8 transfers.
REQ-033 i_valid=8'b1000_0001 with y_ready=1 -> y_sel alternates 0,7,0,7 and never starves either channel.
REQ-034 Single word on channel 3 with y_ready=0 for 5 cycles -> y_valid=1, y_sel=3 and y_data stable all 5 cycles, i_ready=0; then y_ready=1 -> exactly one transfer and xfer_cnt+1.
REQ-035 i_valid=8'hFF, en_mask=8'b0010_0100 -> only channels 2 and 5 are granted, alternating; clearing en_mask[5] while it is held -> that word is still delivered.
REQ-036 Assert rst_n=0 mid-stream with y_valid=1 -> outputs zero immediately without waiting for clk; after release, the first grant goes to the lowest requesting index.
REQ-037 With CNT_W=4, run 20 transfers -> xfer_cnt ends at 15 and holds there.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 8-channel round-robin output mux.
package mux_pkg;

   localparam int unsigned N_CH       = 8;
   localparam int unsigned SEL_W      = 3;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned CNT_W_DEF  = 16;

   // Channel index to one-hot accept vector.
   function automatic logic [N_CH-1:0] sel2oh(input logic [SEL_W-1:0] sel);
      logic [N_CH-1:0] oh;
      oh = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arb8.sv
// Combinational round-robin search: first requester after 'last', wrapping 7->0.
module rr_arb8
   import mux_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] last,
   output logic             gnt_vld,
   output logic [SEL_W-1:0] gnt_idx
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      // Offsets 1..8 so the previous winner is considered last.
      for (int unsigned i = 1; i <= N_CH; i++) begin
         cand = last + SEL_W'(i);
         if (!gnt_vld && req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/rr_mux8to1.sv
// 8:1 round-robin mux with a single registered output stage and saturating transfer counter.
module rr_mux8to1
   import mux_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          i_valid,
   input  logic [N_CH*DATA_W-1:0]   i_data,
   output logic [N_CH-1:0]          i_ready,
   input  logic [N_CH-1:0]          en_mask,
   output logic                     y_valid,
   output logic [DATA_W-1:0]        y_data,
   output logic [SEL_W-1:0]         y_sel,
   input  logic                     y_ready,
   output logic [CNT_W-1:0]         xfer_cnt
);

   logic                y_valid_q, y_valid_d;
   logic [DATA_W-1:0]   y_data_q,  y_data_d;
   logic [SEL_W-1:0]    y_sel_q,   y_sel_d;
   logic [SEL_W-1:0]    last_q,    last_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;

   logic [N_CH-1:0]     req_c;
   logic                free_c;
   logic                gnt_vld_c;
   logic [SEL_W-1:0]    gnt_idx_c;
   logic [DATA_W-1:0]   gnt_data_c;

   assign req_c  = i_valid & en_mask;
   assign free_c = ~y_valid_q | y_ready;

   rr_arb8 u_arb (
      .req     (req_c),
      .last    (last_q),
      .gnt_vld (gnt_vld_c),
      .gnt_idx (gnt_idx_c)
   );

   // Payload of the granted channel.
   always_comb begin
      gnt_data_c = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (gnt_idx_c == SEL_W'(k)) begin
            gnt_data_c = i_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // Accept is held off while in reset so nothing is taken before the first live edge.
   always_comb begin
      i_ready = '0;
      if (rst_n && free_c && gnt_vld_c) begin
         i_ready = sel2oh(gnt_idx_c);
      end
   end

   always_comb begin
      y_valid_d = y_valid_q;
      y_data_d  = y_data_q;
      y_sel_d   = y_sel_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      if (free_c) begin
         y_valid_d = gnt_vld_c;
         if (gnt_vld_c) begin
            y_data_d = gnt_data_c;
            y_sel_d  = gnt_idx_c;
            last_d   = gnt_idx_c;
         end
      end
      if (y_valid_q && y_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // last_q resets to 7 so channel 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_valid_q <= 1'b0;
         y_data_q  <= '0;
         y_sel_q   <= '0;
         last_q    <= SEL_W'(N_CH - 1);
         cnt_q     <= '0;
      end else begin
         y_valid_q <= y_valid_d;
         y_data_q  <= y_data_d;
         y_sel_q   <= y_sel_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

   assign y_valid  = y_valid_q;
   assign y_data   = y_data_q;
   assign y_sel    = y_sel_q;
   assign xfer_cnt = cnt_q;

endmodule
